// File: rtl/sdes_pkg.sv
// rtl/sdes_pkg.sv - S-DES tables, state encoding and permutation/round helpers
package sdes_pkg;

  localparam logic [9:0] DEFAULT_KEY = 10'b0110010100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_R1   = 2'd1,
    ST_R2   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] k1;
    logic [7:0] k2;
  } subkeys_t;

  // Index tables are 1-based from the MSB, as in the textbook cipher description.
  localparam int P10_TBL    [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_TBL     [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int IP_TBL     [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  localparam int IP_INV_TBL [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  localparam int EP_TBL     [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
  localparam int P4_TBL     [4]  = '{2, 4, 3, 1};

  // S-boxes flattened row-major: index = {row[1:0], col[1:0]}.
  localparam logic [1:0] S0_TBL [16] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };
  localparam logic [1:0] S1_TBL [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  function automatic logic [9:0] p10(input logic [9:0] v);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[4'(9 - i)] = v[4'(10 - P10_TBL[4'(i)])];
    return r;
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3'(7 - i)] = v[4'(10 - P8_TBL[3'(i)])];
    return r;
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3'(7 - i)] = v[3'(8 - IP_TBL[3'(i)])];
    return r;
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3'(7 - i)] = v[3'(8 - IP_INV_TBL[3'(i)])];
    return r;
  endfunction

  function automatic logic [7:0] ep(input logic [3:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3'(7 - i)] = v[2'(4 - EP_TBL[3'(i)])];
    return r;
  endfunction

  function automatic logic [3:0] p4(input logic [3:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[2'(3 - i)] = v[2'(4 - P4_TBL[2'(i)])];
    return r;
  endfunction

  // Subkeys: P10, rotate halves left by 1 for K1, by a further 2 for K2, then P8.
  function automatic subkeys_t keygen(input logic [9:0] key);
    logic [9:0] p;
    logic [4:0] l1, r1, l2, r2;
    subkeys_t   sk;
    p  = p10(key);
    l1 = {p[8:5], p[9]};
    r1 = {p[3:0], p[4]};
    l2 = {l1[2:0], l1[4:3]};
    r2 = {r1[2:0], r1[4:3]};
    sk.k1 = p8({l1, r1});
    sk.k2 = p8({l2, r2});
    return sk;
  endfunction

  // One Feistel round: a ^ P4(S0|S1(EP(b) ^ key)); row = outer bits, col = inner bits.
  function automatic logic [3:0] fk(input logic [3:0] a, input logic [3:0] b,
                                    input logic [7:0] key);
    logic [7:0] e;
    logic [1:0] s0;
    logic [1:0] s1;
    e  = ep(b) ^ key;
    s0 = S0_TBL[{e[7], e[4], e[6], e[5]}];
    s1 = S1_TBL[{e[3], e[0], e[2], e[1]}];
    return a ^ p4({s0, s1});
  endfunction

endpackage

// File: rtl/sdes_encrypt_seq_if.sv
// rtl/sdes_encrypt_seq_if.sv - key, plaintext and ciphertext handshake bundle
interface sdes_encrypt_seq_if;
  logic [9:0] key_in;
  logic       key_load;
  logic       key_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output key_in, key_load, in_data, in_valid, out_ready,
    input  key_ready, in_ready, out_data, out_valid
  );

  modport slave (
    input  key_in, key_load, in_data, in_valid, out_ready,
    output key_ready, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/sdes_encrypt_seq_ctrl.sv
// rtl/sdes_encrypt_seq_ctrl.sv - sdes_enc_ctrl: round sequencer and handshake decode
module sdes_enc_ctrl
  import sdes_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   in_valid_i,
  input  logic   out_ready_i,
  input  logic   key_load_i,
  output state_e state_o,
  output logic   in_ready_o,
  output logic   key_ready_o,
  output logic   out_valid_o,
  output logic   accept_o,
  output logic   key_we_o
);

  state_e state_q;
  state_e state_d;

  // State register; reset abandons any block in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake decode; DONE may hand straight over to R1.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    key_ready_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_o  = !rst_i;
        key_ready_o = !rst_i;
        if (in_valid_i) state_d = ST_R1;
      end
      ST_R1:   state_d = ST_R2;
      ST_R2:   state_d = ST_DONE;
      ST_DONE: begin
        in_ready_o = !rst_i && out_ready_i;
        if (out_ready_i) state_d = in_valid_i ? ST_R1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_o     = state_q;
  assign out_valid_o = (state_q == ST_DONE);
  assign accept_o    = in_valid_i && in_ready_o;
  assign key_we_o    = key_load_i && key_ready_o;

endmodule

// File: rtl/sdes_encrypt_seq.sv
// rtl/sdes_encrypt_seq.sv - three-stage S-DES encryptor with one time-shared fk round
module sdes_encrypt_seq #(
  parameter logic [9:0] DEFAULT_KEY = sdes_pkg::DEFAULT_KEY
) (
  input  logic               clk_i,
  input  logic               rst_i,
  sdes_encrypt_seq_if.slave  bus_if
);
  import sdes_pkg::*;

  state_e     state;
  logic       accept;
  logic       key_we;
  logic       in_ready;
  logic       key_ready;
  logic       out_valid;

  logic [9:0] key_q,      key_d;
  logic [3:0] l_q,        l_d;
  logic [3:0] r_q,        r_d;
  logic [3:0] t_q,        t_d;
  logic [7:0] out_data_q, out_data_d;

  subkeys_t   sk;
  logic [3:0] fk_a;
  logic [3:0] fk_b;
  logic [7:0] fk_key;
  logic [3:0] fk_out;
  logic [7:0] ip_out;

  sdes_enc_ctrl u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (bus_if.in_valid),
    .out_ready_i (bus_if.out_ready),
    .key_load_i  (bus_if.key_load),
    .state_o     (state),
    .in_ready_o  (in_ready),
    .key_ready_o (key_ready),
    .out_valid_o (out_valid),
    .accept_o    (accept),
    .key_we_o    (key_we)
  );

  assign sk     = keygen(key_q);
  assign ip_out = ip(bus_if.in_data);

  // Round 1 works on (L,R) with K1; round 2 on (R,T) with K2 -- the swap is just the mux.
  always_comb begin
    fk_a   = l_q;
    fk_b   = r_q;
    fk_key = sk.k1;
    if (state == ST_R2) begin
      fk_a   = r_q;
      fk_b   = t_q;
      fk_key = sk.k2;
    end
  end

  assign fk_out = fk(fk_a, fk_b, fk_key);

  // Datapath next-state: key only changes in IDLE, so a same-edge load covers that block.
  always_comb begin
    key_d      = key_q;
    l_d        = l_q;
    r_d        = r_q;
    t_d        = t_q;
    out_data_d = out_data_q;
    if (key_we) key_d = bus_if.key_in;
    if (accept) {l_d, r_d} = ip_out;
    if (state == ST_R1) t_d = fk_out;
    if (state == ST_R2) out_data_d = ip_inv({fk_out, t_q});
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_q      <= DEFAULT_KEY;
      l_q        <= '0;
      r_q        <= '0;
      t_q        <= '0;
      out_data_q <= '0;
    end else begin
      key_q      <= key_d;
      l_q        <= l_d;
      r_q        <= r_d;
      t_q        <= t_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus_if.in_ready  = in_ready;
  assign bus_if.key_ready = key_ready;
  assign bus_if.out_valid = out_valid;
  assign bus_if.out_data  = out_data_q;

endmodule

// File: tb/tb_sdes_encrypt_seq.sv
// tb/tb_sdes_encrypt_seq.sv - directed-vector bench for sdes_encrypt_seq
module tb_sdes_encrypt_seq;

  localparam logic [9:0] KEY_A   = 10'b1010000010;
  localparam logic [9:0] KEY_DEF = 10'b0110010100;
  localparam logic [7:0] PT_A    = 8'b10010111;
  localparam logic [7:0] CT_A    = 8'b00111000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;

  int s0m [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int s1m [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  sdes_encrypt_seq_if bus();

  sdes_encrypt_seq dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decryptor written with explicit bit picks.
  function automatic logic [9:0] m_p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction
  function automatic logic [7:0] m_p8(input logic [9:0] k);
    return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction
  function automatic logic [7:0] m_ip(input logic [7:0] p);
    return {p[6], p[2], p[5], p[7], p[4], p[0], p[3], p[1]};
  endfunction
  function automatic logic [7:0] m_ipinv(input logic [7:0] p);
    return {p[4], p[7], p[5], p[3], p[1], p[6], p[0], p[2]};
  endfunction
  function automatic logic [3:0] m_f(input logic [3:0] r, input logic [7:0] k);
    logic [7:0] e;
    logic [1:0] a;
    logic [1:0] b;
    e = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
    a = 2'(s0m[{e[7], e[4]}][{e[6], e[5]}]);
    b = 2'(s1m[{e[3], e[0]}][{e[2], e[1]}]);
    return {a[0], b[0], b[1], a[1]};
  endfunction
  function automatic logic [7:0] m_decrypt(input logic [7:0] c, input logic [9:0] key);
    logic [9:0] p;
    logic [4:0] l1, r1, l2, r2;
    logic [7:0] k1, k2, x;
    logic [3:0] a, b;
    p  = m_p10(key);
    l1 = {p[8:5], p[9]};
    r1 = {p[3:0], p[4]};
    l2 = {l1[2:0], l1[4:3]};
    r2 = {r1[2:0], r1[4:3]};
    k1 = m_p8({l1, r1});
    k2 = m_p8({l2, r2});
    x  = m_ip(c);
    a  = x[7:4] ^ m_f(x[3:0], k2);
    b  = x[3:0] ^ m_f(a, k1);
    return m_ipinv({b, a});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [9:0] k);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
  endtask

  // Returns edges from the accept edge (counted as 1) to the edge raising out_valid.
  task automatic send_block(input logic [7:0] pt, output int n);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    bus.in_data  = pt;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.key_in    = '0;
    bus.key_load  = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    rst = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_key_ready", 32'(bus.key_ready), 0);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("idle_in_ready", 32'(bus.in_ready), 1);
    chk("idle_key_ready", 32'(bus.key_ready), 1);

    // known vector, latency
    load_key(KEY_A);
    send_block(PT_A, lat);
    chk("t1_latency", 32'(lat), 3);
    chk("t1_ct", 32'(bus.out_data), 32'(CT_A));
    take();
    chk("t1_out_valid_drop", 32'(bus.out_valid), 0);

    // key load and block on the same IDLE edge
    load_key(KEY_DEF);
    bus.key_in   = KEY_A;
    bus.key_load = 1'b1;
    send_block(PT_A, lat);
    bus.key_load = 1'b0;
    chk("t6_ct", 32'(bus.out_data), 32'(CT_A));
    take();

    // key_load outside IDLE is ignored
    bus.in_data  = PT_A;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t4_key_ready_r1", 32'(bus.key_ready), 0);
    bus.key_in   = KEY_DEF;
    bus.key_load = 1'b1;
    tick();
    chk("t4_key_ready_r2", 32'(bus.key_ready), 0);
    tick();
    chk("t4_key_ready_done", 32'(bus.key_ready), 0);
    bus.key_load = 1'b0;
    chk("t4_ct_cur", 32'(bus.out_data), 32'(CT_A));
    take();
    send_block(PT_A, lat);
    chk("t4_ct_next", 32'(bus.out_data), 32'(CT_A));
    take();

    // backpressure then back-to-back accept
    send_block(PT_A, lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", 32'(bus.out_valid), 1);
      chk("t3_hold_data", 32'(bus.out_data), 32'(CT_A));
      chk("t3_hold_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hC3;
    #1;
    chk("t3_b2b_in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("t3_b2b_valid_low", 32'(bus.out_valid), 0);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("t3_b2b_latency", 32'(lat), 3);
    chk("t3_b2b_roundtrip", 32'(m_decrypt(bus.out_data, KEY_A)), 32'hC3);
    take();

    // reset while in R2
    bus.in_data  = PT_A;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_out_valid", 32'(bus.out_valid), 0);
    chk("t5_out_data", 32'(bus.out_data), 0);
    chk("t5_in_ready", 32'(bus.in_ready), 1);
    chk("t5_key_ready", 32'(bus.key_ready), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_output", 32'(bus.out_valid), 0);
    end
    send_block(8'h5A, lat);
    chk("t5_default_key", 32'(m_decrypt(bus.out_data, KEY_DEF)), 32'h5A);
    take();

    // full plaintext sweep with the default key
    for (int p = 0; p < 256; p++) begin
      send_block(8'(p), lat);
      chk($sformatf("t2_sweep_%0d", p), 32'(m_decrypt(bus.out_data, KEY_DEF)), 32'(p));
      take();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
